// File: rtl/baud_tick_gen.sv
// Baud-rate tick generator: per-bit tx/mid ticks plus OS-times oversampled rx ticks,
// divisor from a rate table or a direct override, changes deferred to bit boundaries.
module baud_tick_gen #(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned WIDTH  = 19,
    parameter int unsigned OS     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [3:0]       baud_sel,
    input  logic             ovr_en,
    input  logic [WIDTH-1:0] div_ovr,
    input  logic             resync,
    output logic             tx_tick,
    output logic             mid_tick,
    output logic             rx_tick,
    output logic [WIDTH-1:0] k_act,
    output logic             cfg_err
);

    localparam int unsigned NUM_RATES = 12;
    localparam int unsigned OS_LOG2   = $clog2(OS);
    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2 * OS);

    // Rounded clocks-per-bit for table index idx, evaluated at elaboration only.
    function automatic longint unsigned rate_div(input int unsigned idx);
        longint unsigned rate;
        case (idx)
            0:       rate = 64'd300;
            1:       rate = 64'd1200;
            2:       rate = 64'd2400;
            3:       rate = 64'd4800;
            4:       rate = 64'd9600;
            5:       rate = 64'd19200;
            6:       rate = 64'd38400;
            7:       rate = 64'd57600;
            8:       rate = 64'd115200;
            9:       rate = 64'd230400;
            10:      rate = 64'd460800;
            11:      rate = 64'd921600;
            default: rate = 64'd300;
        endcase
        return (64'(CLK_HZ) + rate / 64'd2) / rate;
    endfunction

    localparam logic [WIDTH-1:0] K_RESET = WIDTH'(rate_div(0));

    // Unused indices 12..15 alias the slowest rate.
    logic [WIDTH-1:0] div_tab [16];
    for (genvar g = 0; g < 16; g++) begin : g_tab
        localparam int unsigned IDX = (g < NUM_RATES) ? g : 0;
        localparam logic [WIDTH-1:0] DIV = WIDTH'(rate_div(IDX));
        assign div_tab[g] = DIV;
    end

    logic [WIDTH-1:0] bcnt;
    logic [WIDTH-1:0] ocnt;
    logic             running;

    logic [WIDTH-1:0] k_req;
    logic             req_err;
    logic [WIDTH-1:0] ks;
    logic             bit_wrap;
    logic             os_wrap;
    logic             at_mid;

    // Requested divisor and configuration error.
    always_comb begin
        k_req   = div_tab[baud_sel];
        req_err = 1'b0;
        if (ovr_en) begin
            if (div_ovr < MIN_DIV) begin
                k_req   = MIN_DIV;
                req_err = 1'b1;
            end else begin
                k_req = div_ovr;
            end
        end else if (baud_sel >= 4'(NUM_RATES)) begin
            req_err = 1'b1;
        end
    end

    // Counter decode against the divisor of the bit in progress.
    always_comb begin
        ks = k_act >> OS_LOG2;
        if (ks == '0) begin
            ks = WIDTH'(1);
        end
        bit_wrap = (bcnt >= k_act - WIDTH'(1));
        os_wrap  = (ocnt >= ks - WIDTH'(1));
        at_mid   = (bcnt == (k_act >> 1) - WIDTH'(1));
    end

    // First enabled edge and resync both park the counters at phase zero without a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt     <= '0;
            ocnt     <= '0;
            running  <= 1'b0;
            k_act    <= K_RESET;
            tx_tick  <= 1'b0;
            mid_tick <= 1'b0;
            rx_tick  <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err  <= req_err;
            tx_tick  <= 1'b0;
            mid_tick <= 1'b0;
            rx_tick  <= 1'b0;
            if (!enable) begin
                bcnt    <= '0;
                ocnt    <= '0;
                running <= 1'b0;
                k_act   <= k_req;
            end else if (!running || resync) begin
                bcnt    <= '0;
                ocnt    <= '0;
                running <= 1'b1;
                if (resync) begin
                    k_act <= k_req;
                end
            end else begin
                mid_tick <= at_mid;
                rx_tick  <= os_wrap;
                if (bit_wrap) begin
                    bcnt    <= '0;
                    tx_tick <= 1'b1;
                    k_act   <= k_req;
                end else begin
                    bcnt <= bcnt + WIDTH'(1);
                end
                if (bit_wrap || os_wrap) begin
                    ocnt <= '0;
                end else begin
                    ocnt <= ocnt + WIDTH'(1);
                end
            end
        end
    end

endmodule
